// File: rtl/prbs_pkg.sv
// Shared state type, PRBS-7 polynomial constants and prediction helper for the PRBS checker
// and the upstream PRBS source.
package prbs_pkg;

  localparam int unsigned PRBS7_W   = 7;
  localparam int unsigned PRBS7_TAP = 6;

  typedef enum logic [0:0] {
    StSearch,
    StLocked
  } chk_state_e;

  // State bit 0 holds the newest bit; prediction taps at positions w and tap.
  function automatic logic prbs_pred(input logic [31:0] state, input int unsigned w,
                                     input int unsigned tap);
    return state[5'(w - 1)] ^ state[5'(tap - 1)];
  endfunction

endpackage

// File: rtl/prbs_lfsr.sv
// Shift/feedback register for x^W + x^Tap + 1; shifts in either an external bit or its own
// feedback.
module prbs_lfsr
  import prbs_pkg::*;
#(
  parameter int unsigned W   = PRBS7_W,
  parameter int unsigned Tap = PRBS7_TAP
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         shift_i,
  input  logic         sel_ext_i,
  input  logic         ext_bit_i,
  output logic [W-1:0] state_o,
  output logic         fb_o
);

  logic [W-1:0] state_q, state_d;

  assign fb_o    = prbs_pred(32'(state_q), W, Tap);
  assign state_o = state_q;

  always_comb begin
    state_d = state_q;
    if (shift_i) begin
      state_d = {state_q[W-2:0], sel_ext_i ? ext_bit_i : fb_o};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= '0;
    end else begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/prbs_stream_checker.sv
// Self-synchronising serial PRBS checker with lock tracking and saturating error count.
// Optional 32-bit locked-sample counter on port bit_count when PRBS_CHK_BITCNT_EN is defined.
module prbs_stream_checker
  import prbs_pkg::*;
#(
  parameter int unsigned LFSR_W      = PRBS7_W,
  parameter int unsigned TAP_B       = PRBS7_TAP,
  parameter int unsigned LOCK_CNT    = 16,
  parameter int unsigned WIN         = 32,
  parameter int unsigned LOSS_THRESH = 4,
  parameter int unsigned ERR_CNT_W   = 16
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 in,
  input  logic                 clear,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_count
`ifdef PRBS_CHK_BITCNT_EN
  ,
  output logic [31:0]          bit_count
`endif
);

  localparam int unsigned FillW  = $clog2(LFSR_W + 1);
  localparam int unsigned MatchW = $clog2(LOCK_CNT + 1);
  localparam int unsigned WinW   = $clog2(WIN);
  localparam int unsigned WerrW  = $clog2(LOSS_THRESH + 1);

  chk_state_e           state_q, state_d;
  logic [FillW-1:0]     fill_q, fill_d;
  logic [MatchW-1:0]    match_q, match_d;
  logic [WinW-1:0]      win_q, win_d;
  logic [WerrW-1:0]     werr_q, werr_d, werr_sum;
  logic [ERR_CNT_W-1:0] err_count_q, err_count_d;
  logic                 err_pulse_q, err_pulse_d;
  logic [LFSR_W-1:0]    lfsr;
  logic                 pred, mismatch, lfsr_zero, win_wrap;

  // Searching: track the incoming stream; locked: free-run so each bad bit costs one error.
  prbs_lfsr #(
    .W   (LFSR_W),
    .Tap (TAP_B)
  ) u_lfsr (
    .clk_i     (clock),
    .rst_ni    (reset_n),
    .shift_i   (en),
    .sel_ext_i (state_q == StSearch),
    .ext_bit_i (in),
    .state_o   (lfsr),
    .fb_o      (pred)
  );

  assign mismatch  = in ^ pred;
  assign lfsr_zero = (lfsr == '0);
  assign win_wrap  = (win_q == WinW'(WIN - 1));

  always_comb begin
    state_d     = state_q;
    fill_d      = fill_q;
    match_d     = match_q;
    win_d       = win_q;
    werr_d      = werr_q;
    err_count_d = err_count_q;
    err_pulse_d = 1'b0;
    werr_sum    = '0;
    if (en) begin
      unique case (state_q)
        StSearch: begin
          if (fill_q != FillW'(LFSR_W)) begin
            fill_d = fill_q + 1'b1;
          end else if (lfsr_zero || mismatch) begin
            match_d = '0;
          end else if (match_q == MatchW'(LOCK_CNT - 1)) begin
            state_d = StLocked;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            match_d = match_q + 1'b1;
          end
        end
        StLocked: begin
          err_pulse_d = mismatch;
          if (mismatch && (err_count_q != '1)) begin
            err_count_d = err_count_q + 1'b1;
          end
          // A mismatch on the wrap sample opens the new window's tally.
          werr_sum = (win_wrap ? '0 : werr_q) + WerrW'(mismatch);
          if (werr_sum >= WerrW'(LOSS_THRESH)) begin
            state_d = StSearch;
            fill_d  = '0;
            match_d = '0;
            win_d   = '0;
            werr_d  = '0;
          end else begin
            werr_d = werr_sum;
            win_d  = win_wrap ? '0 : win_q + 1'b1;
          end
        end
      endcase
    end
    if (clear) begin
      err_count_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= StSearch;
      fill_q      <= '0;
      match_q     <= '0;
      win_q       <= '0;
      werr_q      <= '0;
      err_count_q <= '0;
      err_pulse_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fill_q      <= fill_d;
      match_q     <= match_d;
      win_q       <= win_d;
      werr_q      <= werr_d;
      err_count_q <= err_count_d;
      err_pulse_q <= err_pulse_d;
    end
  end

  assign locked    = (state_q == StLocked);
  assign err_pulse = err_pulse_q;
  assign err_count = err_count_q;

`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count_q, bit_count_d;

  always_comb begin
    bit_count_d = bit_count_q;
    if (clear) begin
      bit_count_d = '0;
    end else if (en && (state_q == StLocked) && (bit_count_q != '1)) begin
      bit_count_d = bit_count_q + 1'b1;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      bit_count_q <= '0;
    end else begin
      bit_count_q <= bit_count_d;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_prbs_stream_checker.sv
// Bench for prbs_stream_checker: directed scenarios plus a randomized phase, checked against a
// sample-level reference model; a second instance with a 3-bit error counter shares the inputs.
module tb_prbs_stream_checker;

  localparam int LfsrW      = 7;
  localparam int LockCnt    = 16;
  localparam int Win        = 32;
  localparam int LossThresh = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        en = 1'b0;
  logic        in = 1'b0;
  logic        clear = 1'b0;
  logic        locked, err_pulse, locked3, err_pulse3;
  logic [15:0] err_count;
  logic [2:0]  err_count3;
`ifdef PRBS_CHK_BITCNT_EN
  logic [31:0] bit_count, bit_count3;
`endif

  int n_vec  = 0;
  int n_fail = 0;

  // Reference model state
  bit     m_hist[$];
  bit     m_locked, m_pulse;
  int     m_fill, m_match, m_win, m_werr;
  longint m_err, m_bits;

  bit       seq[256];
  logic [6:0] seed;
  int       pos, lock_at, en_cnt, pulses, pulse_step;
  bit       seen_lock, e_r, f_r, c_r;

  always #5 clock = ~clock;

  prbs_stream_checker dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .in        (in),
    .clear     (clear),
    .locked    (locked),
    .err_pulse (err_pulse),
    .err_count (err_count)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_count (bit_count)
`endif
  );

  prbs_stream_checker #(
    .ERR_CNT_W (3)
  ) dut_w3 (
    .clock     (clock),
    .reset_n   (reset_n),
    .en        (en),
    .in        (in),
    .clear     (clear),
    .locked    (locked3),
    .err_pulse (err_pulse3),
    .err_count (err_count3)
`ifdef PRBS_CHK_BITCNT_EN
    ,
    .bit_count (bit_count3)
`endif
  );

  task automatic model_reset();
    m_hist = {};
    repeat (LfsrW) m_hist.push_back(1'b0);
    m_locked = 0; m_pulse = 0;
    m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
    m_err = 0; m_bits = 0;
  endtask

  // Prediction is the XOR of the bits seen 7 and 6 samples ago (oldest first in m_hist).
  task automatic model_step(input bit b, input bit e, input bit c);
    bit pred, mis;
    int ones;
    m_pulse = 0;
    if (e) begin
      pred = m_hist[0] ^ m_hist[1];
      mis  = (b != pred);
      if (!m_locked) begin
        ones = 0;
        foreach (m_hist[i]) ones += int'(m_hist[i]);
        if (m_fill < LfsrW) m_fill++;
        else if (ones == 0 || mis) m_match = 0;
        else begin
          m_match++;
          if (m_match == LockCnt) begin
            m_locked = 1; m_match = 0; m_win = 0; m_werr = 0;
          end
        end
        m_hist.push_back(b);
      end else begin
        m_bits++;
        if (mis) begin m_pulse = 1; m_err++; end
        if (m_win == Win - 1) begin m_win = 0; m_werr = 0; end
        else m_win++;
        if (mis) m_werr++;
        if (m_werr >= LossThresh) begin
          m_locked = 0; m_fill = 0; m_match = 0; m_win = 0; m_werr = 0;
        end
        m_hist.push_back(pred);
      end
      void'(m_hist.pop_front());
    end
    if (c) begin m_err = 0; m_bits = 0; end
  endtask

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all();
    check_val("locked", 64'(locked), 64'(m_locked));
    check_val("locked_w3", 64'(locked3), 64'(m_locked));
    check_val("err_pulse", 64'(err_pulse), 64'(m_pulse));
    check_val("err_pulse_w3", 64'(err_pulse3), 64'(m_pulse));
    check_val("err_count", 64'(err_count), 64'((m_err > 65535) ? 65535 : m_err));
    check_val("err_count_w3", 64'(err_count3), 64'((m_err > 7) ? 7 : m_err));
`ifdef PRBS_CHK_BITCNT_EN
    check_val("bit_count", 64'(bit_count), 64'(m_bits));
    check_val("bit_count_w3", 64'(bit_count3), 64'(m_bits));
`endif
  endtask

  // Called at posedge+1; drives, clocks, updates the model, checks at the next posedge+1.
  task automatic step(input bit b, input bit e, input bit c);
    in = b; en = e; clear = c;
    @(posedge clock);
    model_step(b, e, c);
    #1;
    check_all();
  endtask

  task automatic feed(input bit e, input bit flip, input bit c);
    bit b;
    b = e ? (seq[pos % 127] ^ flip) : 1'($urandom);
    step(b, e, c);
    if (e) pos++;
  endtask

  // Reset asserted between edges: outputs must clear before the next edge.
  task automatic do_reset();
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all();
    check_val("rst_locked", 64'(locked), 64'd0);
    check_val("rst_err_count", 64'(err_count), 64'd0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    pos = 0;
  endtask

  initial begin
    seed = 7'h01;
    for (int k = 0; k < 7; k++) seq[k] = seed[6-k];
    for (int n = 7; n < 256; n++) seq[n] = seq[n-7] ^ seq[n-6];

    @(posedge clock);
    #1;
    do_reset();

    // 1: clean stream locks on the 23rd sample with no errors
    lock_at = 0; pulses = 0;
    for (int i = 1; i <= 200; i++) begin
      feed(1'b1, 1'b0, 1'b0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
      if (err_pulse === 1'b1) pulses++;
    end
    check_val("t1_lock_sample", 64'(lock_at), 64'd23);
    check_val("t1_pulses", 64'(pulses), 64'd0);

    // 2: one corrupted bit gives one pulse, one cycle later
    pulses = 0; pulse_step = 0;
    for (int i = 1; i <= 60; i++) begin
      feed(1'b1, (i == 30), 1'b0);
      if (err_pulse === 1'b1) begin pulses++; pulse_step = i; end
    end
    check_val("t2_pulses", 64'(pulses), 64'd1);
    check_val("t2_pulse_step", 64'(pulse_step), 64'd30);
    check_val("t2_err_count", 64'(err_count), 64'd1);
    check_val("t2_locked", 64'(locked), 64'd1);

    // 3: stuck-at-0 input loses lock and never relocks
    feed(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 64; i++) step(1'b0, 1'b1, 1'b0);
    check_val("t3_lost", 64'(locked), 64'd0);
    seen_lock = 0;
    for (int i = 0; i < 100; i++) begin
      step(1'b0, 1'b1, 1'b0);
      if (locked === 1'b1) seen_lock = 1;
    end
    check_val("t3_no_relock", 64'(seen_lock), 64'd0);

    // 4: en toggling every cycle; lock counted in enabled samples
    do_reset();
    lock_at = 0; en_cnt = 0;
    for (int i = 0; i < 60; i++) begin
      feed((i % 2) == 0, 1'b0, 1'b0);
      if ((i % 2) == 0) en_cnt++;
      if (locked === 1'b1 && lock_at == 0) lock_at = en_cnt;
    end
    check_val("t4_lock_sample", 64'(lock_at), 64'd23);

    // 5: ten spaced errors saturate the 3-bit counter; clear beats a coincident error
    do_reset();
    for (int i = 0; i < 30; i++) feed(1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 120; i++) feed(1'b1, (i % 12) == 0, 1'b0);
    check_val("t5_locked", 64'(locked), 64'd1);
    check_val("t5_cnt16", 64'(err_count), 64'd10);
    check_val("t5_sat3", 64'(err_count3), 64'd7);
    feed(1'b1, 1'b1, 1'b1);
    check_val("t5_clr_pulse", 64'(err_pulse), 64'd1);
    check_val("t5_clr_cnt", 64'(err_count), 64'd0);
    check_val("t5_clr_cnt_w3", 64'(err_count3), 64'd0);

    // 6: reset while locked, then relock after 23 samples
    for (int i = 0; i < 5; i++) feed(1'b1, 1'b0, 1'b0);
    check_val("t6_pre_locked", 64'(locked), 64'd1);
    do_reset();
    lock_at = 0;
    for (int i = 1; i <= 30; i++) begin
      feed(1'b1, 1'b0, 1'b0);
      if (locked === 1'b1 && lock_at == 0) lock_at = i;
    end
    check_val("t6_relock_sample", 64'(lock_at), 64'd23);

    // Randomized: sparse enables, occasional bit flips and clears
    for (int i = 0; i < 600; i++) begin
      e_r = ($urandom_range(0, 3) != 0);
      f_r = ($urandom_range(0, 19) == 0);
      c_r = e_r && ($urandom_range(0, 39) == 0);
      feed(e_r, f_r, c_r);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
